// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between a CPU port and a DMA port.
// One access is in flight at a time. The FSM runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack).
// By default the CPU has priority over the DMA.
// Optional feature: define MEM_ARBITER_ANTISTARVE_EN to grant DMA after STARVE_LIMIT consecutive
// CPU grants made while DMA was waiting.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        RST_bar,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  owner
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   wcnt, wcnt_d;
  logic            lat_we, lat_we_d;
  logic            grant_cpu_c, grant_dma_c, final_c;
  logic [DW-1:0]   mem_addr_d, mem_wdata_d, cpu_rdata_d, dma_rdata_d;
  logic            mem_we_d, mem_oe_d, cpu_ack_d, dma_ack_d;
  logic [1:0]      owner_d;

`ifdef MEM_ARBITER_ANTISTARVE_EN
  localparam int unsigned SW = 4;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit_c;

  assign starve_hit_c = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_dma_c  = (state == IDLE) && dma_req && (!cpu_req || starve_hit_c);
  assign grant_cpu_c  = (state == IDLE) && cpu_req && !grant_dma_c;

  // Count CPU grants won while DMA waits; clear on DMA grant or when DMA is not requesting.
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_dma_c || !dma_req) begin
        starve_cnt <= '0;
      end else if (grant_cpu_c && !starve_hit_c) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`else
  assign grant_cpu_c = (state == IDLE) && cpu_req;
  assign grant_dma_c = (state == IDLE) && dma_req && !cpu_req;
`endif

  assign final_c = (state == ACCESS) && (wcnt == '0);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // Next-state logic: grant from IDLE, count down in ACCESS, one ack cycle in DONE.
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    case (state)
      IDLE: begin
        if (grant_cpu_c || grant_dma_c) begin
          state_d = ACCESS;
          wcnt_d  = CW'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (wcnt == '0) state_d = DONE;
        else            wcnt_d  = wcnt - CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; the memory strobes follow the next state.
  always_comb begin
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    lat_we_d    = lat_we;
    owner_d     = owner;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_cpu_c) begin
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          lat_we_d    = cpu_we;
          owner_d     = OWN_CPU;
        end else if (grant_dma_c) begin
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          lat_we_d    = dma_we;
          owner_d     = OWN_DMA;
        end
      end
      ACCESS: begin
        if (final_c) begin
          cpu_ack_d = (owner == OWN_CPU);
          dma_ack_d = (owner == OWN_DMA);
          if (!lat_we && owner == OWN_CPU) cpu_rdata_d = mem_rdata;
          if (!lat_we && owner == OWN_DMA) dma_rdata_d = mem_rdata;
        end
      end
      DONE:    owner_d = OWN_NONE;
      default: owner_d = OWN_NONE;
    endcase
    mem_we_d = (state_d == ACCESS) && lat_we_d;
    mem_oe_d = (state_d == ACCESS) && !lat_we_d;
  end

  // Output register; reset clears every strobe and data output immediately.
  always_ff @(posedge clk or negedge RST_bar) begin
    if (!RST_bar) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_we    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      owner     <= OWN_NONE;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      lat_we    <= lat_we_d;
      mem_we    <= mem_we_d;
      mem_oe    <= mem_oe_d;
      owner     <= owner_d;
      cpu_ack   <= cpu_ack_d;
      dma_ack   <= dma_ack_d;
      cpu_rdata <= cpu_rdata_d;
      dma_rdata <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: u0 uses WAIT_STATES=1, u1 uses WAIT_STATES=0 and shares u0's inputs.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic        cpu_ack, dma_ack, mem_we, mem_oe;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [1:0]  owner;

  logic        cpu_ack1, dma_ack1, mem_we1, mem_oe1;
  logic [15:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
  logic [1:0]  owner1;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(3)) u0 (
    .clk(clk), .RST_bar(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(3)) u1 (
    .clk(clk), .RST_bar(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack1), .dma_rdata(dma_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_oe(mem_oe1),
    .mem_rdata(mem_rdata), .owner(owner1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_cpu, n_dma, n_both;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;

    // Reset state, checked before any clock edge.
    #3;
    chk("rst_owner", 16'(owner), 16'h0);
    chk("rst_we_oe", {14'h0, mem_we, mem_oe}, 16'h0);
    chk("rst_acks", {14'h0, cpu_ack, dma_ack}, 16'h0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 16'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_owner", 16'(owner), 16'h0);
    chk("idle_strobes", {12'h0, mem_we, mem_oe, cpu_ack, dma_ack}, 16'h0);

    // CPU read of 0x1234 returning 0xBEEF; the address changes after the grant.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; mem_rdata = 16'hBEEF;
    tick();
    chk("rd_c1_owner", 16'(owner), 16'h1);
    chk("rd_c1_oe", {14'h0, mem_oe, mem_we}, 16'h2);
    chk("rd_c1_addr", mem_addr, 16'h1234);
    chk("rd_c1_ack", 16'(cpu_ack), 16'h0);
    cpu_addr = 16'hFFFF;
    tick();
    chk("rd_c2_oe", 16'(mem_oe), 16'h1);
    chk("rd_c2_addr", mem_addr, 16'h1234);
    chk("rd_c2_ack", 16'(cpu_ack), 16'h0);
    tick();
    chk("rd_c3_ack", 16'(cpu_ack), 16'h1);
    chk("rd_c3_rdata", cpu_rdata, 16'hBEEF);
    chk("rd_c3_owner", 16'(owner), 16'h1);
    chk("rd_c3_oe", 16'(mem_oe), 16'h0);
    cpu_req = 0;
    tick();
    chk("rd_c4_owner", 16'(owner), 16'h0);
    chk("rd_c4_ack", 16'(cpu_ack), 16'h0);
    tick(); tick();

    // DMA write of 0x5A5A to 0x0100.
    dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 16'h5A5A;
    tick();
    chk("wr_c1_we_oe", {14'h0, mem_we, mem_oe}, 16'h2);
    chk("wr_c1_addr", mem_addr, 16'h0100);
    chk("wr_c1_wdata", mem_wdata, 16'h5A5A);
    chk("wr_c1_owner", 16'(owner), 16'h2);
    tick();
    chk("wr_c2_we", 16'(mem_we), 16'h1);
    chk("wr_c2_ack", 16'(dma_ack), 16'h0);
    tick();
    chk("wr_c3_acks", {14'h0, dma_ack, cpu_ack}, 16'h2);
    chk("wr_c3_we", 16'(mem_we), 16'h0);
    dma_req = 0; dma_we = 0;
    tick();
    chk("wr_c4_ack", 16'(dma_ack), 16'h0);
    chk("wr_dma_rdata", dma_rdata, 16'h0000);
    chk("wr_cpu_rdata", cpu_rdata, 16'hBEEF);
    tick(); tick();

    // Simultaneous requests: CPU first, DMA granted in cycle 4, dma_ack in cycle 7.
    cpu_req = 1; cpu_addr = 16'h0010; dma_req = 1; dma_addr = 16'h0020; mem_rdata = 16'h1111;
    tick();
    chk("both_c1_owner", 16'(owner), 16'h1);
    chk("both_c1_addr", mem_addr, 16'h0010);
    tick(); tick();
    chk("both_c3_acks", {14'h0, cpu_ack, dma_ack}, 16'h2);
    cpu_req = 0;
    tick();
    chk("both_c4_owner", 16'(owner), 16'h0);
    tick();
    chk("both_c5_owner", 16'(owner), 16'h2);
    chk("both_c5_addr", mem_addr, 16'h0020);
    mem_rdata = 16'h2222;
    tick();
    chk("both_c6_ack", 16'(dma_ack), 16'h0);
    tick();
    chk("both_c7_acks", {14'h0, dma_ack, cpu_ack}, 16'h2);
    chk("both_c7_drdata", dma_rdata, 16'h2222);
    chk("both_c7_crdata", cpu_rdata, 16'h1111);
    dma_req = 0;
    tick(); tick(); tick();

    // Both requests held: acks land in cycles 3, 7, 11, 15.
    cpu_req = 1; dma_req = 1;
    n_cpu = 0; n_dma = 0; n_both = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (cpu_ack) n_cpu++;
      if (dma_ack) n_dma++;
      if (cpu_ack && dma_ack) n_both++;
    end
    cpu_req = 0; dma_req = 0;
`ifdef MEM_ARBITER_ANTISTARVE_EN
    chk("hold_cpu_acks", 16'(n_cpu), 16'd3);
    chk("hold_dma_acks", 16'(n_dma), 16'd1);
`else
    chk("hold_cpu_acks", 16'(n_cpu), 16'd4);
    chk("hold_dma_acks", 16'(n_dma), 16'd0);
`endif
    chk("hold_dual_ack", 16'(n_both), 16'd0);
    tick(); tick(); tick(); tick();

    // Reset pulsed during a CPU write; the held request is regranted after release.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0ABC; cpu_wdata = 16'h7777;
    tick();
    chk("rw_c1_we", 16'(mem_we), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_async_we", 16'(mem_we), 16'h0);
    chk("rw_async_owner", 16'(owner), 16'h0);
    chk("rw_async_addr", mem_addr, 16'h0);
    tick();
    tick();
    chk("rw_inrst_ack", 16'(cpu_ack), 16'h0);
    rst_n = 1'b1;
    tick();
    chk("rw_regrant_owner", 16'(owner), 16'h1);
    chk("rw_regrant_addr", mem_addr, 16'h0ABC);
    chk("rw_regrant_we", 16'(mem_we), 16'h1);
    tick();
    chk("rw_r2_ack", 16'(cpu_ack), 16'h0);
    tick();
    chk("rw_r3_ack", 16'(cpu_ack), 16'h1);
    cpu_req = 0; cpu_we = 0;
    tick(); tick(); tick(); tick(); tick();

    // WAIT_STATES=0 instance: back-to-back CPU reads ack every third cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300; mem_rdata = 16'hA000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("ws0_ack_c%0d", k), 16'(cpu_ack1), 16'((k % 3) == 2));
      if ((k % 3) == 2) chk($sformatf("ws0_rdata_c%0d", k), cpu_rdata1, 16'hA000 + 16'(k - 1));
      mem_rdata = 16'hA000 + 16'(k);
    end
    cpu_req = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra memory cycles per access, range 0-7.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3: consecutive CPU grants tolerated while DMA waits, range 1-15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_bar, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports cpu_req / cpu_we, input, 1 each: CPU access request and write select.
REQ-006 SHALL have ports cpu_addr / cpu_wdata, input, 16 each: CPU address and write data.
REQ-007 SHALL have ports cpu_ack, output, 1, and cpu_rdata, output, 16: CPU completion strobe and read data.
REQ-008 SHALL have ports dma_req, dma_we, dma_addr[15:0], dma_wdata[15:0], dma_ack, dma_rdata[15:0]: DMA port, same meanings as the CPU port.
REQ-009 SHALL have ports mem_addr[15:0], mem_wdata[15:0], mem_we, mem_oe, all outputs, and mem_rdata[15:0], input: shared memory port.
REQ-010 SHALL have port owner, output, 2: 00 none, 01 CPU, 10 DMA.

Function
REQ-011 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-012 In IDLE with any request high, SHALL latch the winner's addr, wdata and we at the clock edge, set owner, load a wait counter with WAIT_STATES, and enter ACCESS.
REQ-013 Default priority SHALL be CPU over DMA when both requests are high in the same IDLE cycle.
REQ-014 ACCESS SHALL last WAIT_STATES+1 cycles: the counter decrements each cycle, and the FSM exits to DONE when the counter is 0.
REQ-015 During ACCESS, mem_addr and mem_wdata SHALL hold the latched values, with mem_we=latched we and mem_oe=!latched we; outside ACCESS, mem_we=mem_oe=0.
REQ-016 On the final ACCESS edge of a read, SHALL register mem_rdata into the owner's rdata output, which then holds until that owner's next read completes.
REQ-017 In DONE, SHALL assert the owner's ack for exactly one cycle, then return to IDLE with owner=00.
REQ-018 Latency SHALL be: request sampled in cycle 0, ack high in cycle WAIT_STATES+2, next arbitration in cycle WAIT_STATES+3.
REQ-019 A requester SHALL hold req and its inputs stable until ack; changes to its inputs after the grant SHALL have no effect on the access in flight.
REQ-020 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-021 Only one ack SHALL be high in any cycle; ack SHALL never be asserted without a granted request.
REQ-022 With no requests pending, the FSM SHALL stay in IDLE, and all strobes and owner SHALL be 0.

Reset
REQ-023 RST_bar low SHALL immediately force IDLE, owner=00, both acks=0, mem_we=mem_oe=0, mem_addr=mem_wdata=0, both rdata=0, wait counter=0, and starvation counter=0.
REQ-024 Reset during ACCESS SHALL abort the access with no ack; the aborted requester must re-request.
REQ-025 Arbitration SHALL begin on the first rising edge after RST_bar goes high.

Configuration
REQ-026 With macro MEM_ARBITER_ANTISTARVE_EN defined, SHALL count CPU grants made while dma_req is high.
REQ-027 With MEM_ARBITER_ANTISTARVE_EN defined, when the count equals STARVE_LIMIT, the next arbitration SHALL grant DMA despite CPU priority.
REQ-028 With MEM_ARBITER_ANTISTARVE_EN defined, the count SHALL clear on any DMA grant and on any arbitration with dma_req low, and SHALL saturate at STARVE_LIMIT.
REQ-029 Without MEM_ARBITER_ANTISTARVE_EN, priority SHALL be strict CPU-first, with no starvation counter logic.

Verification
REQ-030 CPU read of 0x1234, WAIT_STATES=1, memory returning 0xBEEF -> mem_oe high for cycles 1-2, cpu_ack in cycle 3, cpu_rdata=0xBEEF, owner=01 in cycles 1-3.
REQ-031 DMA write of 0x5A5A to 0x0100 -> mem_we high for WAIT_STATES+1 cycles with mem_addr=0x0100 and mem_wdata=0x5A5A; dma_ack for 1 cycle; cpu_ack stays 0.
REQ-032 cpu_req and dma_req both raised in cycle 0 -> CPU is served first; DMA is granted in cycle WAIT_STATES+3 and dma_ack arrives in cycle 2*WAIT_STATES+5.
REQ-033 cpu_req and dma_req held high continuously, STARVE_LIMIT=3, ANTISTARVE_EN defined -> grant order CPU,CPU,CPU,DMA,CPU,...; without the macro -> CPU only, dma_ack never asserted.
REQ-034 RST_bar pulsed low mid-ACCESS of a CPU write -> mem_we drops without waiting for a clock edge, no cpu_ack, owner=00; after release, a held cpu_req is regranted normally.
REQ-035 WAIT_STATES=0 back-to-back CPU reads -> ack every 3rd cycle, each rdata matching the mem_rdata of its own access.
